// File: rtl/input_spi.sv
// Serial byte receiver: 3-cycle symbols (marker 1, data bit, stop 0), LSB first, gated by active-low en.
// Optional HUNT idle timeout is enabled with the INPUT_SPI_TIMEOUT_EN macro.
module input_spi #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic       en,
    output logic [7:0] out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, HUNT, DATA, STOP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        do_shift, do_bit, do_drop, do_err;
    logic        tmo;

    assign busy = (bit_cnt != 4'd0) || (state == DATA) || (state == STOP);

`ifdef INPUT_SPI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    logic [TW-1:0] tcnt;

    // tcnt holds the number of earlier consecutive idle cycles, so this fires on idle cycle TIMEOUT+1
    assign tmo = (state == HUNT) && !en && !in && (bit_cnt != 4'd0) && (tcnt == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst)
            tcnt <= '0;
        else if ((state == HUNT) && !en && !in && (bit_cnt != 4'd0) && !tmo)
            tcnt <= tcnt + 1'b1;
        else
            tcnt <= '0;
    end
`else
    logic unused_timeout;
    assign tmo            = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_shift  = 1'b0;
        do_bit    = 1'b0;
        do_drop   = 1'b0;
        do_err    = 1'b0;
        case (state)
            IDLE: begin
                if (!en)
                    state_nxt = HUNT;
            end
            HUNT: begin
                if (en) begin
                    state_nxt = IDLE;
                    do_drop   = 1'b1;
                    do_err    = busy;
                end else if (in) begin
                    state_nxt = DATA;
                end else if (tmo) begin
                    do_drop = 1'b1;
                    do_err  = 1'b1;
                end
            end
            DATA: begin
                if (en) begin
                    state_nxt = IDLE;
                    do_drop   = 1'b1;
                    do_err    = 1'b1;
                end else begin
                    state_nxt = STOP;
                    do_shift  = 1'b1;
                end
            end
            STOP: begin
                if (en) begin
                    state_nxt = IDLE;
                    do_drop   = 1'b1;
                    do_err    = 1'b1;
                end else begin
                    state_nxt = HUNT;
                    if (in) begin
                        do_drop = 1'b1;
                        do_err  = 1'b1;
                    end else begin
                        do_bit = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: shift register, bit counter and the held output byte
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            out       <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= do_err;
            if (do_drop) begin
                bit_cnt <= 4'd0;
                shreg   <= 8'h00;
            end else if (do_shift) begin
                shreg <= {in, shreg[7:1]};
            end else if (do_bit) begin
                if (bit_cnt == 4'd7) begin
                    out     <= shreg;
                    valid   <= 1'b1;
                    bit_cnt <= 4'd0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_spi.sv
// Directed scoreboard bench for input_spi: expected bytes are queued at send time and popped on valid.
module tb_input_spi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in  = 1'b0;
    logic       en  = 1'b1;
    logic [7:0] out;
    logic       valid, busy, frame_err;

    int         vectors    = 0;
    int         miscompares = 0;
    int         ncyc       = 0;
    int         nvalid     = 0;
    int         nferr      = 0;
    int         last_valid = 0;
    int         marker_cyc = 0;
    logic [7:0] expq[$];

    input_spi #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .in(in), .en(en),
        .out(out), .valid(valid), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        logic [7:0] e;
        chk("valid_and_frame_err", {31'd0, valid & frame_err}, 32'd0);
        if (frame_err === 1'b1) nferr++;
        if (valid === 1'b1) begin
            nvalid++;
            last_valid = ncyc;
            if (expq.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("out_byte", {24'd0, out}, {24'd0, e});
            end
        end
    endtask

    // Drive one cycle of inputs, then look at the outputs that posedge produced
    task automatic cyc(input logic i, input logic e);
        in = i;
        en = e;
        @(posedge clk);
        @(negedge clk);
        ncyc++;
        observe();
    endtask

    task automatic send_bit(input logic b, input logic stopv);
        cyc(1'b1, 1'b0);
        marker_cyc = ncyc;
        cyc(b, 1'b0);
        cyc(stopv, 1'b0);
    endtask

    task automatic send_bits(input logic [7:0] v, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            send_bit(v[i], 1'b0);
            if (i != last)
                for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0);
        end
    endtask

    initial begin
        int v0, f0, vc1;
        // Reset with en/in trying to start a frame
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        chk("rst_out", {24'd0, out}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);

        // 0xA5 with one gap cycle between symbols, plus latency check
        f0 = nferr;
        expq.push_back(8'hA5);
        send_bits(8'hA5, 0, 7, 1);
        chk("a5_valid_count", nvalid, 1);
        chk("a5_latency", last_valid, marker_cyc + 2);
        chk("a5_out_hold", {24'd0, out}, 32'hA5);
        chk("a5_no_frame_err", nferr, f0);

        // 0x3C then 0xFF with zero gaps
        expq.push_back(8'h3C);
        expq.push_back(8'hFF);
        send_bits(8'h3C, 0, 7, 0);
        vc1 = last_valid;
        send_bits(8'hFF, 0, 7, 0);
        chk("b2b_valid_count", nvalid, 3);
        chk("b2b_spacing", last_valid - vc1, 24);

        // 0x81 with a bad stop on bit 3, then clean 0x55
        v0 = nvalid;
        f0 = nferr;
        send_bits(8'h81, 0, 2, 0);
        send_bit(1'b0, 1'b1);
        chk("stop_err_frame_err", nferr, f0 + 1);
        chk("stop_err_no_valid", nvalid, v0);
        chk("stop_err_out_kept", {24'd0, out}, 32'hFF);
        chk("stop_err_busy", {31'd0, busy}, 32'd0);
        expq.push_back(8'h55);
        send_bits(8'h55, 0, 7, 0);
        chk("after_err_out", {24'd0, out}, 32'h55);

        // Abort via en=1 (in=1 at the same time) after 4 bits of 0x0F
        send_bits(8'h0F, 0, 3, 0);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        f0 = nferr;
        cyc(1'b1, 1'b1);
        chk("abort_frame_err", {31'd0, frame_err}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out_kept", {24'd0, out}, 32'h55);
        cyc(1'b1, 1'b1);
        chk("abort_single_pulse", nferr, f0 + 1);

        // Reset mid-byte drops the partial byte silently
        cyc(1'b0, 1'b0);
        send_bits(8'h07, 0, 2, 0);
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        chk("midrst_out", {24'd0, out}, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);

        // Two bits, long idle gap in HUNT, then the remaining six bits
        f0 = nferr;
        v0 = nvalid;
        send_bits(8'hC3, 0, 1, 0);
        for (int g = 0; g < 16; g++) cyc(1'b0, 1'b0);
`ifdef INPUT_SPI_TIMEOUT_EN
        chk("timeout_frame_err", nferr, f0 + 1);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
`else
        chk("gap_no_frame_err", nferr, f0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        expq.push_back(8'hC3);
        send_bits(8'hC3, 2, 7, 0);
        chk("gap_valid", nvalid, v0 + 1);
        chk("gap_out", {24'd0, out}, 32'hC3);
`endif

        chk("scoreboard_empty", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_spi.md
INPUT_SPI -- requirements
Module: input_spi

Interface
REQ-001 Parameter: TIMEOUT, 15, max idle cycles allowed in HUNT mid-byte before abort (used only with INPUT_SPI_TIMEOUT_EN).
REQ-002 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in  input  1  serial data line; each bit is a 3-cycle symbol: marker 1, data bit, stop 0; LSB first.
REQ-005 Port: en  input  1  link enable, active-low; 0 = transmitter talking, 1 = link idle.
REQ-006 Port: out  output  8  last received byte, held until the next good byte.
REQ-007 Port: valid  output  1  one-cycle pulse when out is updated.
REQ-008 Port: busy  output  1  high while a byte is partially received (bit count > 0, or state DATA or STOP).
REQ-009 Port: frame_err  output  1  one-cycle pulse when a partial byte is discarded.

Function
REQ-010 The FSM SHALL have states IDLE, HUNT, DATA and STOP, a 4-bit bit counter (0..8) and an 8-bit shift register.
REQ-011 IDLE: while en=1, remain; en=0 -> HUNT next cycle; in is ignored in IDLE.
REQ-012 HUNT: in=1 with en=0 -> DATA; in=0 -> remain in HUNT (inter-bit and inter-byte gap cycles allowed).
REQ-013 DATA: the shift register SHALL shift right with in loaded into bit 7 (LSB-first assembly); the FSM SHALL then go to STOP.
REQ-014 STOP: in=0 -> bit count +1, then HUNT; in=1 -> frame_err pulse, bit count cleared, shift register discarded, then HUNT.
REQ-015 When a STOP with in=0 makes bit count reach 8, out SHALL be loaded from the shift register and valid SHALL be pulsed in the next cycle, and bit count SHALL be cleared.
REQ-016 Latency: marker sampled in cycle t; valid=1 with the new out in cycle t+3 of the 8th symbol.
REQ-017 A first-received bit of b0 SHALL appear at out[0]; the eighth-received bit SHALL appear at out[7].
REQ-018 en=1 in HUNT, DATA or STOP SHALL go to IDLE next cycle and clear bit count; if busy was 1, frame_err SHALL be pulsed.
REQ-019 en=1 SHALL take priority over every in value in the same cycle.
REQ-020 Back-to-back bytes with zero gap cycles (marker directly after the 8th stop) SHALL be received without loss.
REQ-021 valid and frame_err SHALL never be 1 in the same cycle.
REQ-022 out SHALL be unchanged by errors, aborts and timeouts.

Reset
REQ-023 rst=1 SHALL force IDLE, bit count 0, shift register 0x00, timeout counter 0, out=0x00, valid=0, busy=0, frame_err=0 on the next posedge.
REQ-024 rst SHALL take priority over en and in, and a reset mid-byte SHALL drop the partial byte with no frame_err pulse.

Configuration
REQ-025 Macro INPUT_SPI_TIMEOUT_EN defined: in HUNT with bit count > 0, a counter SHALL count consecutive in=0 cycles.
REQ-026 With INPUT_SPI_TIMEOUT_EN, a count exceeding TIMEOUT SHALL pulse frame_err, clear bit count, and stay in HUNT.
REQ-027 With INPUT_SPI_TIMEOUT_EN, the timeout counter SHALL clear on any marker and in every state other than HUNT.
REQ-028 Macro INPUT_SPI_TIMEOUT_EN undefined: no timeout counter; HUNT SHALL wait indefinitely and the TIMEOUT parameter SHALL be ignored.

Verification
REQ-029 en=0, byte 0xA5 sent as 8 symbols with one 0 gap cycle between symbols -> valid pulse once, out=0xA5, frame_err never 1.
REQ-030 Bytes 0x3C then 0xFF back-to-back with zero gaps -> two valid pulses 24 cycles apart, out=0x3C then 0xFF.
REQ-031 Byte 0x81 with the stop phase of bit 3 driven to 1 -> frame_err pulse at that symbol, no valid, out keeps its previous value; a following clean 0x55 -> out=0x55.
REQ-032 en raised to 1 after 4 bits of 0x0F -> IDLE, one frame_err pulse, busy=0, out unchanged; rst=1 mid-byte -> all outputs 0, no frame_err.
REQ-033 With INPUT_SPI_TIMEOUT_EN and TIMEOUT=15, 2 bits then in=0 held for 16 cycles -> frame_err pulse on the 16th cycle; without the macro, the same stimulus -> no frame_err, and the remaining 6 bits sent later complete the byte with valid.
